uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 16: baud_tick pulses per serial bit (4-bit tick counter; legal value 16 only).
REQ-002 SHALL have port clk, input, 1: single clock; all state on posedge clk.
REQ-003 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port baud_tick, input, 1: 16x-oversample enable, one-cycle pulse.
REQ-005 SHALL have port fifo_empty, input, 1: TX FIFO empty flag.
REQ-006 SHALL have port fifo_data, input, 8: TX FIFO head word, combinational from FIFO.
REQ-007 SHALL have port fifo_pop, output, 1: one-cycle pop strobe to TX FIFO.
REQ-008 SHALL have port lcr, input, 7: [1:0] word length 00=5..11=8 bits; [2] stop_2; [3] parity_en; [4] even_par; [5] stick_par; [6] break_ctl.
REQ-009 SHALL have port tx, output, 1: serial line, idle high.
REQ-010 SHALL have port tx_busy, output, 1: frame in progress.
REQ-011 SHALL have port tx_done, output, 1: one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-013 IDLE with fifo_empty=0: assert fifo_pop for exactly one cycle, latch fifo_data and lcr[5:0] in the same cycle, clear tick and bit counters, enter START; baud_tick not required.
REQ-014 IDLE with fifo_empty=1: fifo_pop=0, no state change.
REQ-015 Each bit state SHALL last exactly 16 baud_tick pulses; transition on the cycle of the 16th tick (tick counter 15 and baud_tick=1).
REQ-016 tx SHALL be registered: START drives 0, DATA drives latched data LSB first, PARITY drives parity bit, STOP1/STOP2 drive 1, IDLE drives 1.
REQ-017 DATA SHALL send 5+lcr[1:0] bits, then go to PARITY if parity_en, else STOP1.
REQ-018 Parity SHALL be computed over the sent bits only: even_par=1 gives XOR of bits; even_par=0 gives its inverse; stick_par=1 forces the bit to ~even_par.
REQ-019 STOP1 SHALL go to STOP2 if stop_2, else finish; STOP2 finishes. Two full stop bits for every word length.
REQ-020 On finish: tx_done=1 for one cycle; return to IDLE; next pop no earlier than the following cycle (one clk gap, zero bit-time gap).
REQ-021 tx_busy SHALL be 1 from the cycle after the pop through the tx_done cycle inclusive, and 0 otherwise.
REQ-022 lcr[5:0] changes mid-frame SHALL not affect the current frame.
REQ-023 break_ctl=1 SHALL force tx=0 immediately (combinational override of the registered bit); the FSM, counters and pops continue unaffected.
REQ-024 fifo_pop SHALL never assert outside IDLE or while fifo_empty=1.

Reset
REQ-025 rstn=0 SHALL asynchronously force: state IDLE, counters 0, data latch 0x00, tx=1, fifo_pop=0, tx_busy=0, tx_done=0.
REQ-026 Reset mid-frame SHALL abort the frame with no tx_done; after release, a nonempty FIFO is popped afresh.

Verification
REQ-027 0x55, lcr=0x03 (8N1): one pop; tx = 0,1,0,1,0,1,0,1,0,1 at 16 ticks/bit (160 ticks); one tx_done.
REQ-028 0x41, lcr=0x1A (7E1): tx = 0,1,0,0,0,0,0,1,0(parity),1; 10 bits.
REQ-029 0x1F, lcr=0x0C (5O2): tx = 0,1,1,1,1,1,0(parity),1,1; 9 bits.
REQ-030 Two bytes 0xA5,0x3C queued: second pop one clk after the first tx_done; no idle bit time between frames; two tx_done pulses.
REQ-031 lcr[6] set during DATA of 0xFF: tx=0 immediately; clear break: frame resumes on schedule with tx_done at the original time.
REQ-032 rstn low during DATA bit 3: tx=1, tx_busy=0 immediately; no tx_done; FIFO popped once more after release if nonempty.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
// Handshake between the UART transmit controller and its TX FIFO.
//   fifo_empty : FIFO has no word to send
//   fifo_data  : head-of-FIFO word, combinational from the FIFO
//   fifo_pop   : one-cycle strobe that consumes the head word
// Modports:
//   master : the transmit controller (consumes words, drives the pop strobe)
//   slave  : the FIFO side (presents words, receives the pop strobe)
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_pop
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit framer. Pops one word from the TX FIFO, then shifts out
// start bit, 5..8 data bits (LSB first), optional parity and one or two stop
// bits, each bit lasting TICKS_PER_BIT pulses of the 16x baud enable.
// Ports:
//   clk       : clock, all state on its rising edge
//   rstn      : asynchronous active-low reset
//   baud_tick : 16x-oversample enable, one-cycle pulse
//   fifo      : TX FIFO handshake (empty / head data / pop strobe)
//   lcr       : line control [1:0] len-5, [2] two stop bits, [3] parity enable,
//               [4] even parity, [5] stick parity, [6] break
//   tx        : serial output, idle high
//   tx_busy   : a frame is being shifted out
//   tx_done   : one-cycle pulse on the last tick of the final stop bit
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    // The tick counter is 4 bits wide, so 16 is the only meaningful value.
    parameter int TICKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           baud_tick,
    uart_tx_ctrl_if.master fifo,
    input  logic [6:0]     lcr,
    output logic           tx,
    output logic           tx_busy,
    output logic           tx_done
);

    localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] tick_reg, tick_next;
    logic [2:0] bit_reg, bit_next;
    logic [7:0] data_reg, data_next;
    logic [5:0] lcr_reg, lcr_next;
    logic       tx_reg, tx_next;

    logic       pop;
    logic       bit_end;
    logic [2:0] last_bit;
    logic [7:0] word_mask;
    logic       parity_xor;
    logic       parity_bit;

    // Data bits that belong to the frame: bits 0..4 always, 5..7 by length.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_word_mask
            if (gi < 5) begin : g_fixed
                assign word_mask[gi] = 1'b1;
            end else begin : g_len
                assign word_mask[gi] = ({1'b0, lcr_reg[1:0]} >= 3'(gi - 4));
            end
        end
    endgenerate

    assign last_bit   = 3'd4 + {1'b0, lcr_reg[1:0]};
    assign parity_xor = ^(data_reg & word_mask);
    // Stick parity overrides the computed value with the inverted even flag.
    assign parity_bit = lcr_reg[5] ? ~lcr_reg[4]
                                   : (lcr_reg[4] ? parity_xor : ~parity_xor);

    // 16th tick of the current bit: the only cycle a bit state may advance.
    assign bit_end = baud_tick && (tick_reg == TICK_LAST);

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        data_next  = data_reg;
        lcr_next   = lcr_reg;
        pop        = 1'b0;
        tx_done    = 1'b0;

        if (state_reg != IDLE && baud_tick) begin
            tick_next = tick_reg + 4'd1;   // wraps to 0 exactly on bit_end
        end

        case (state_reg)
            IDLE: begin
                // Popping needs no baud tick; the frame timing starts at START.
                if (!fifo.fifo_empty) begin
                    pop        = 1'b1;
                    data_next  = fifo.fifo_data;
                    lcr_next   = lcr[5:0];
                    tick_next  = 4'd0;
                    bit_next   = 3'd0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_reg == last_bit) begin
                        state_next = lcr_reg[3] ? PARITY : STOP1;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP1;
            end
            STOP1: begin
                if (bit_end) begin
                    if (lcr_reg[2]) begin
                        state_next = STOP2;
                    end else begin
                        state_next = IDLE;
                        tx_done    = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (bit_end) begin
                    state_next = IDLE;
                    tx_done    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // The line level is registered: it follows the state being entered.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_next[bit_next];
            PARITY:  tx_next = parity_bit;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            tick_reg  <= 4'd0;
            bit_reg   <= 3'd0;
            data_reg  <= 8'h00;
            lcr_reg   <= 6'd0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            data_reg  <= data_next;
            lcr_reg   <= lcr_next;
            tx_reg    <= tx_next;
        end
    end

    // The pop is decoded from IDLE, which reset also forces, so it is gated
    // by rstn to stay quiet while reset is held. Break acts on the live lcr
    // bit and overrides the line without touching the framer.
    assign fifo.fifo_pop = pop & rstn;
    assign tx            = tx_reg & ~(lcr[6] & rstn);
    assign tx_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rstn;
    logic       baud_tick;
    logic [6:0] lcr;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    uart_tx_ctrl_if fif ();

    uart_tx_ctrl #(.TICKS_PER_BIT(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .baud_tick (baud_tick),
        .fifo      (fif),
        .lcr       (lcr),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Bench-side FIFO
    logic [7:0] q[$];

    // Behavioural model: frame as a list of line levels, 16 ticks per entry.
    bit   m_busy = 1'b0;
    bit   m_bits[16];
    int   m_nbits = 0;
    int   m_ticks = 0;

    // DUT-side observations
    int   cyc = 0;
    int   pop_count = 0;
    int   done_count = 0;
    int   pop_cycles[$];
    int   done_cycles[$];
    logic [15:0] cap = 16'd0;
    int   cap_ticks = 0;
    logic [15:0] last_cap = 16'd0;
    int   last_ticks = 0;

    int   tick_pct = 70;
    bit   rand_mode = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Build the expected line sequence from the framing rules.
    function automatic void build_frame(input logic [7:0] d, input logic [6:0] l);
        int  n;
        int  k;
        bit  p;
        n = 5 + int'(l[1:0]);
        k = 0;
        p = 1'b0;
        m_bits[k++] = 1'b0;
        for (int i = 0; i < n; i++) begin
            m_bits[k++] = d[i];
            p ^= d[i];
        end
        if (l[3]) m_bits[k++] = l[5] ? ~l[4] : (l[4] ? p : ~p);
        m_bits[k++] = 1'b1;
        if (l[2]) m_bits[k++] = 1'b1;
        m_nbits = k;
    endfunction

    task automatic refresh_fifo();
        fif.fifo_empty = (q.size() == 0);
        fif.fifo_data  = (q.size() != 0) ? q[0] : 8'($urandom);
    endtask

    // One clock: compare at negedge, advance model at posedge, drive at +1.
    task automatic step();
        bit exp_pop;
        bit exp_tx;
        bit exp_busy;
        bit exp_done;
        bit dut_pop;
        int idx;
        @(negedge clk);
        cyc++;
        if (!rstn) begin
            m_busy = 1'b0;
            exp_pop = 1'b0; exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
        end else if (!m_busy) begin
            exp_pop = !fif.fifo_empty; exp_tx = !lcr[6]; exp_busy = 1'b0; exp_done = 1'b0;
        end else begin
            idx = m_ticks / 16;
            if (idx > 15) idx = 15;
            exp_pop  = 1'b0;
            exp_tx   = m_bits[idx] & !lcr[6];
            exp_busy = 1'b1;
            exp_done = baud_tick && (m_ticks == 16 * m_nbits - 1);
        end
        check("fifo_pop", fif.fifo_pop, exp_pop);
        check("tx", tx, exp_tx);
        check("tx_busy", tx_busy, exp_busy);
        check("tx_done", tx_done, exp_done);

        dut_pop = rstn && fif.fifo_pop;
        if (dut_pop) begin
            pop_count++;
            pop_cycles.push_back(cyc);
        end
        if (!rstn) begin
            cap = 16'd0;
            cap_ticks = 0;
        end else if (tx_busy && baud_tick) begin
            if (cap_ticks % 16 == 8) cap = {cap[14:0], tx};
            cap_ticks++;
        end
        if (rstn && tx_done) begin
            done_count++;
            done_cycles.push_back(cyc);
            last_cap   = cap;
            last_ticks = cap_ticks;
            cap        = 16'd0;
            cap_ticks  = 0;
        end

        @(posedge clk);
        if (rstn) begin
            if (!m_busy && exp_pop) begin
                build_frame(fif.fifo_data, lcr);
                m_busy  = 1'b1;
                m_ticks = 0;
            end else if (m_busy) begin
                if (exp_done) m_busy = 1'b0;
                else if (baud_tick) m_ticks++;
            end
        end

        #1;
        if (dut_pop && q.size() > 0) void'(q.pop_front());
        if (rand_mode) begin
            if (q.size() < 3 && $urandom_range(0, 9) < 3) q.push_back(8'($urandom));
            if ($urandom_range(0, 99) < 2) lcr[5:0] = 6'($urandom);
            if (lcr[6]) begin
                if ($urandom_range(0, 9) == 0) lcr[6] = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                lcr[6] = 1'b1;
            end
        end
        refresh_fifo();
        baud_tick = ($urandom_range(0, 99) < tick_pct);
    endtask

    task automatic run_until_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_count < target && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (done_count < target) begin
            fails++;
            $display("FAIL %s timeout: got %0d tx_done expected %0d", name, done_count, target);
        end
    endtask

    task automatic directed(input logic [7:0] d, input logic [6:0] l, input int nbits,
                            input logic [15:0] exp_bits, input string name);
        int d0;
        int p0;
        d0 = done_count;
        p0 = pop_count;
        lcr = l;
        q.push_back(d);
        refresh_fifo();
        run_until_done(d0 + 1, 3000, name);
        for (int i = 0; i < 4; i++) step();
        check_int({name, " bits"}, int'(last_cap), int'(exp_bits));
        check_int({name, " ticks"}, last_ticks, nbits * 16);
        check_int({name, " pops"}, pop_count, p0 + 1);
        check_int({name, " dones"}, done_count, d0 + 1);
        $display("[TB] frame %s data=%02h lcr=%02h bits=%0h ticks=%0d", name, d, l, last_cap, last_ticks);
    endtask

    initial begin
        int d0;
        int p0;
        int n;

        rstn = 1'b0;
        baud_tick = 1'b0;
        lcr = 7'h03;
        refresh_fifo();
        #12;
        check("reset tx", tx, 1'b1);
        check("reset tx_busy", tx_busy, 1'b0);
        check("reset tx_done", tx_done, 1'b0);
        check("reset fifo_pop", fif.fifo_pop, 1'b0);
        q.push_back(8'h77);
        refresh_fifo();
        #1;
        check("reset fifo_pop nonempty", fif.fifo_pop, 1'b0);
        q.delete();
        refresh_fifo();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Literal frames
        directed(8'h55, 7'h03, 10, 16'b0000000101010101, "8N1_55");
        directed(8'h41, 7'h1A, 10, 16'b0000000100000101, "7E1_41");
        directed(8'h1F, 7'h0C, 9,  16'b0000000011111011, "5O2_1F");

        // Back-to-back frames: second pop one clock after first tx_done
        lcr = 7'h03;
        pop_cycles.delete();
        done_cycles.delete();
        d0 = done_count;
        q.push_back(8'hA5);
        q.push_back(8'h3C);
        refresh_fifo();
        run_until_done(d0 + 2, 6000, "b2b");
        tests++;
        if (pop_cycles.size() < 2 || done_cycles.size() < 1) begin
            fails++;
            $display("FAIL b2b gap: got %0d pops expected 2", pop_cycles.size());
        end else begin
            check_int("b2b gap", pop_cycles[1] - done_cycles[0], 1);
        end
        check_int("b2b bits", int'(last_cap), int'(16'b0000000001111001));
        $display("[TB] frame b2b A5,3C dones=%0d", done_count - d0);

        // Break in the middle of DATA
        d0 = done_count;
        p0 = pop_count;
        lcr = 7'h03;
        q.push_back(8'hFF);
        refresh_fifo();
        n = 0;
        while (!(m_busy && m_ticks >= 48) && n < 2000) begin step(); n++; end
        lcr[6] = 1'b1;
        #1;
        check("break tx", tx, 1'b0);
        for (int i = 0; i < 40; i++) step();
        lcr[6] = 1'b0;
        run_until_done(d0 + 1, 3000, "break");
        check_int("break ticks", last_ticks, 160);
        check_int("break pops", pop_count, p0 + 1);
        $display("[TB] frame break FF ticks=%0d", last_ticks);

        // Reset during data bit 3
        d0 = done_count;
        p0 = pop_count;
        lcr = 7'h03;
        q.push_back(8'h96);
        q.push_back(8'h5A);
        refresh_fifo();
        n = 0;
        while (!(m_busy && m_ticks >= 67) && n < 2000) begin step(); n++; end
        rstn = 1'b0;
        #1;
        m_busy = 1'b0;
        check("rst tx", tx, 1'b1);
        check("rst tx_busy", tx_busy, 1'b0);
        check("rst tx_done", tx_done, 1'b0);
        check("rst fifo_pop", fif.fifo_pop, 1'b0);
        for (int i = 0; i < 3; i++) step();
        rstn = 1'b1;
        check_int("rst no done", done_count, d0);
        step();
        check_int("rst repop", pop_count, p0 + 2);
        run_until_done(d0 + 1, 3000, "rst");
        check_int("rst bits", int'(last_cap), int'(16'b0000000010110101));
        $display("[TB] frame reset-abort 96, then 5A bits=%0h", last_cap);

        // Randomized traffic with live lcr and break changes
        rand_mode = 1'b1;
        tick_pct = 60;
        d0 = done_count;
        run_until_done(d0 + 25, 40000, "random");
        rand_mode = 1'b0;
        lcr[6] = 1'b0;
        $display("[TB] random phase frames=%0d pops=%0d", done_count - d0, pop_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
